// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-2 demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_DEPTH = 2;
  localparam int unsigned DEMUX_PTR_W = 1;
  localparam int unsigned DEMUX_CNT_W = 2;

  // Occupancy counter, 0..DEMUX_DEPTH.
  typedef logic [DEMUX_CNT_W-1:0] fill_t;

  localparam fill_t FILL_EMPTY = 2'd0;
  localparam fill_t FILL_FULL  = 2'd2;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry circular FIFO with a registered head output.
// The head register holds its last value while empty (0 after reset).
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [size-1:0] data_i,
  input  logic            pop_i,
  output logic [size-1:0] data_o,
  output logic            full_o,
  output logic            empty_o,
  output fill_t           count_o
);

  logic [size-1:0]        r_mem [DEMUX_DEPTH];
  logic [DEMUX_PTR_W-1:0] r_wptr;
  logic [DEMUX_PTR_W-1:0] r_rptr;
  fill_t                  r_cnt;
  logic [size-1:0]        r_head;

  logic [DEMUX_PTR_W-1:0] w_wptr_d;
  logic [DEMUX_PTR_W-1:0] w_rptr_d;
  fill_t                  w_cnt_d;
  logic [size-1:0]        w_head_d;
  logic                   w_push;
  logic                   w_pop;

  // Requests are qualified here so the FIFO can never overflow or underflow.
  assign w_push = push_i && (r_cnt != FILL_FULL);
  assign w_pop  = pop_i && (r_cnt != FILL_EMPTY);

  // Next pointers, occupancy and head value.
  always_comb begin
    w_wptr_d = r_wptr;
    w_rptr_d = r_rptr;
    w_cnt_d  = r_cnt;
    w_head_d = r_head;
    if (w_push) w_wptr_d = r_wptr + 1'b1;
    if (w_pop)  w_rptr_d = r_rptr + 1'b1;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_d = r_cnt + 2'd1;
      2'b01:   w_cnt_d = r_cnt - 2'd1;
      default: w_cnt_d = r_cnt;
    endcase
    // The new head is the incoming beat when it lands at the next read slot.
    if (w_cnt_d != FILL_EMPTY) begin
      if (w_push && (r_wptr == w_rptr_d)) w_head_d = data_i;
      else                                w_head_d = r_mem[w_rptr_d];
    end
  end

  // Storage, pointer and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEMUX_DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= FILL_EMPTY;
      r_head <= '0;
    end else begin
      if (w_push) r_mem[r_wptr] <= data_i;
      r_wptr <= w_wptr_d;
      r_rptr <= w_rptr_d;
      r_cnt  <= w_cnt_d;
      r_head <= w_head_d;
    end
  end

  assign data_o  = r_head;
  assign count_o = r_cnt;
  assign full_o  = (r_cnt == FILL_FULL);
  assign empty_o = (r_cnt == FILL_EMPTY);

endmodule

// File: rtl/demux_1_to_2_buf.sv
// Registered 1-to-2 demultiplexer: one input stream steered per beat into
// one of two independently drained 2-entry buffers.
module demux_1_to_2_buf
  import demux_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic            valid0_o,
  input  logic            ready0_i,
  output logic [size-1:0] data1_o,
  output logic            valid1_o,
  input  logic            ready1_i,
  output fill_t           fill0_o,
  output fill_t           fill1_o
);

  logic w_full0;
  logic w_full1;
  logic w_empty0;
  logic w_empty1;
  logic w_push0;
  logic w_push1;

  // ready_o depends only on select and fill state, never on consumer readies.
  always_comb begin
    ready_o = select_i ? !w_full1 : !w_full0;
    w_push0 = valid_i && ready_o && !select_i;
    w_push1 = valid_i && ready_o && select_i;
  end

  demux_fifo2 #(
    .size (size)
  ) u_fifo0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push0),
    .data_i  (data_i),
    .pop_i   (ready0_i),
    .data_o  (data0_o),
    .full_o  (w_full0),
    .empty_o (w_empty0),
    .count_o (fill0_o)
  );

  demux_fifo2 #(
    .size (size)
  ) u_fifo1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push1),
    .data_i  (data_i),
    .pop_i   (ready1_i),
    .data_o  (data1_o),
    .full_o  (w_full1),
    .empty_o (w_empty1),
    .count_o (fill1_o)
  );

  assign valid0_o = !w_empty0;
  assign valid1_o = !w_empty1;

endmodule
